// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down step counter family.
package counter_pkg;

  typedef enum logic [1:0] {CNT_IDLE, CNT_RUN, CNT_DONE} cnt_state_e;

  // Callers widen their operands to 32 bits and narrow the result back to their own WIDTH.
  function automatic logic [31:0] clamp_count(input logic [31:0] value,
                                              input logic [31:0] max_count);
    return (value > max_count) ? max_count : value;
  endfunction

endpackage

// File: rtl/updown_step.sv
// Combinational single-step next value for a modulus-(MAX_COUNT+1) up/down counter.
module updown_step #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] next_count,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

  // At a boundary the counter either holds (saturate) or jumps to the opposite end (wrap).
  always_comb begin
    next_count = count;
    wrapped    = 1'b0;
    if (up) begin
      if (count >= MaxVal) begin
        next_count = sat ? MaxVal : '0;
        wrapped    = ~sat;
      end else begin
        next_count = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        next_count = sat ? '0 : MaxVal;
        wrapped    = ~sat;
      end else begin
        next_count = count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_step_counter.sv
// Up/down counter with programmable modulus, wrap/saturate, load/clear and a one-shot
// IDLE/RUN/DONE sequencer used as an iteration counter by sequential multipliers.
module updown_step_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

  cnt_state_e       state;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] step_value;
  logic             step_wrapped;

  assign load_clamped = WIDTH'(clamp_count(32'(load_value), 32'(MAX_COUNT)));
  assign terminal     = up ? MaxVal : '0;
  assign tc           = (count == terminal);
  assign busy         = (state == CNT_RUN);
  assign done         = (state == CNT_DONE);

  updown_step #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT)
  ) u_step (
    .count      (count),
    .up         (up),
    .sat        (sat),
    .next_count (step_value),
    .wrapped    (step_wrapped)
  );

  // A wrap or saturate hold can only start from the current terminal, so in RUN a step
  // taken from the terminal (after a mid-run direction change) just completes the run.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      state <= CNT_IDLE;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      state <= CNT_IDLE;
      wrap  <= 1'b0;
    end else if (start && state != CNT_RUN) begin
      count <= load_clamped;
      state <= (load_clamped == terminal) ? CNT_DONE : CNT_RUN;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        CNT_RUN: begin
          if (en) begin
            if (tc) begin
              state <= CNT_DONE;
            end else begin
              count <= step_value;
              if (step_value == terminal) state <= CNT_DONE;
            end
          end
        end
        default: begin
          state <= CNT_IDLE;
          if (en) begin
            count <= step_value;
            wrap  <= step_wrapped;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_step_counter.sv
// Self-checking bench: three counter configurations driven in lockstep and compared
// against a behavioural model every cycle, plus directed checks with fixed expectations.
module tb_updown_step_counter;

  logic       clk = 1'b0;
  logic       rst, clr, load, start, en, up, sat;
  logic [3:0] lv;

  logic [3:0] count_a;
  logic [1:0] count_b, count_c;
  logic       tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;

  int checks = 0;
  int errors = 0;

  int m_count[3];
  bit m_run[3], m_done[3], m_wrap[3];
  int m_max[3]  = '{9, 3, 1};
  int m_mask[3] = '{15, 3, 3};

  always #5 clk = ~clk;

  updown_step_counter #(.WIDTH(4), .MAX_COUNT(9)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .start(start), .load_value(lv),
    .en(en), .up(up), .sat(sat), .count(count_a), .tc(tc_a), .wrap(wrap_a),
    .busy(busy_a), .done(done_a));

  updown_step_counter #(.WIDTH(2), .MAX_COUNT(3)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .start(start), .load_value(lv[1:0]),
    .en(en), .up(up), .sat(sat), .count(count_b), .tc(tc_b), .wrap(wrap_b),
    .busy(busy_b), .done(done_b));

  updown_step_counter #(.WIDTH(2), .MAX_COUNT(1)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .start(start), .load_value(lv[1:0]),
    .en(en), .up(up), .sat(sat), .count(count_c), .tc(tc_c), .wrap(wrap_c),
    .busy(busy_c), .done(done_c));

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour of one edge for every configuration, written from the rules
  // of the counter rather than its implementation.
  task automatic modelEdge();
    for (int k = 0; k < 3; k++) begin
      int v, term;
      v = int'(lv) & m_mask[k];
      if (v > m_max[k]) v = m_max[k];
      term = up ? m_max[k] : 0;
      if (rst || clr) begin
        m_count[k] = 0; m_run[k] = 0; m_done[k] = 0; m_wrap[k] = 0;
      end else if (load) begin
        m_count[k] = v; m_run[k] = 0; m_done[k] = 0; m_wrap[k] = 0;
      end else if (start && !m_run[k]) begin
        m_count[k] = v; m_wrap[k] = 0;
        m_done[k]  = (v == term);
        m_run[k]   = (v != term);
      end else begin
        m_wrap[k] = 0;
        if (m_run[k]) begin
          m_done[k] = 0;
          if (en) begin
            if (m_count[k] != term) m_count[k] = up ? m_count[k] + 1 : m_count[k] - 1;
            if (m_count[k] == term) begin
              m_run[k] = 0; m_done[k] = 1;
            end
          end
        end else begin
          m_done[k] = 0;
          if (en) begin
            if (up) begin
              if (m_count[k] == m_max[k]) begin
                if (!sat) begin m_count[k] = 0; m_wrap[k] = 1; end
              end else m_count[k]++;
            end else begin
              if (m_count[k] == 0) begin
                if (!sat) begin m_count[k] = m_max[k]; m_wrap[k] = 1; end
              end else m_count[k]--;
            end
          end
        end
      end
    end
  endtask

  task automatic checkDut(input int k, input logic [31:0] cnt, input logic t, input logic w,
                          input logic b, input logic d);
    int term;
    term = up ? m_max[k] : 0;
    checkOutput($sformatf("dut%0d.count", k), cnt, m_count[k]);
    checkOutput($sformatf("dut%0d.tc", k), {31'b0, t}, (m_count[k] == term) ? 1 : 0);
    checkOutput($sformatf("dut%0d.wrap", k), {31'b0, w}, m_wrap[k]);
    checkOutput($sformatf("dut%0d.busy", k), {31'b0, b}, m_run[k]);
    checkOutput($sformatf("dut%0d.done", k), {31'b0, d}, m_done[k]);
  endtask

  task automatic applyStimulus(input bit r, input bit c, input bit l, input bit s,
                               input bit e, input bit u, input bit sa, input int v);
    rst = r; clr = c; load = l; start = s; en = e; up = u; sat = sa; lv = 4'(v);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkDut(0, 32'(count_a), tc_a, wrap_a, busy_a, done_a);
    checkDut(1, 32'(count_b), tc_b, wrap_b, busy_b, done_b);
    checkDut(2, 32'(count_c), tc_c, wrap_c, busy_c, done_c);
  endtask

  initial begin
    rst = 1; clr = 0; load = 0; start = 0; en = 0; up = 0; sat = 0; lv = 0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset.count", 32'(count_a), 0);
    checkOutput("reset.tc_down", 32'(tc_a), 1);

    // Reset in the middle of a run
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 3);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("midrun.count", 32'(count_a), 5);
    checkOutput("midrun.busy", 32'(busy_a), 1);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("rst.count", 32'(count_a), 0);
    checkOutput("rst.busy", 32'(busy_a), 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("rst.nodone", 32'(done_a), 0);

    // Wrap up
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 7);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("wrapup.count9", 32'(count_a), 9);
    checkOutput("wrapup.tc", 32'(tc_a), 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("wrapup.count0", 32'(count_a), 0);
    checkOutput("wrapup.wrap", 32'(wrap_a), 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("wrapup.wrap_off", 32'(wrap_a), 0);

    // Clamp then saturate down
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 12);
    checkOutput("clamp.count", 32'(count_a), 9);
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 0, 1, 0);
    checkOutput("satdown.count", 32'(count_a), 0);
    checkOutput("satdown.tc", 32'(tc_a), 1);
    checkOutput("satdown.wrap", 32'(wrap_a), 0);

    // Run with stalls, then zero-length run
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 3);
    begin
      bit pattern[8] = '{1, 1, 0, 1, 0, 1, 1, 1};
      foreach (pattern[i]) applyStimulus(0, 0, 0, 0, pattern[i], 1, 0, 0);
    end
    checkOutput("run.count", 32'(count_a), 9);
    checkOutput("run.done", 32'(done_a), 1);
    checkOutput("run.busy_end", 32'(busy_a), 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("run.done_once", 32'(done_a), 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 9);
    checkOutput("zero.done", 32'(done_a), 1);
    checkOutput("zero.busy", 32'(busy_a), 0);

    // Priority
    applyStimulus(0, 0, 1, 1, 1, 1, 0, 4);
    checkOutput("prio.load_count", 32'(count_a), 4);
    checkOutput("prio.load_busy", 32'(busy_a), 0);
    applyStimulus(0, 1, 1, 0, 0, 1, 0, 6);
    checkOutput("prio.clr_count", 32'(count_a), 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 2);
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 7);
    checkOutput("prio.start_ignored", 32'(count_a), 3);
    checkOutput("prio.still_busy", 32'(busy_a), 1);

    // Narrow configurations: down-wrap from 0
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("w2m3.count", 32'(count_b), 3);
    checkOutput("w2m3.wrap", 32'(wrap_b), 1);
    checkOutput("w2m1.count", 32'(count_c), 1);
    checkOutput("w2m1.wrap", 32'(wrap_c), 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("w2m1.tc", 32'(tc_c), 1);
    checkOutput("w2m3.count2", 32'(count_b), 2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, c, l, s, e, u, sa;
      r  = ($urandom_range(0, 59) == 0);
      c  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 14) == 0);
      s  = ($urandom_range(0, 6) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = ($urandom_range(0, 9) == 0) ? ~up : up;
      sa = ($urandom_range(0, 9) == 0) ? ~sat : sat;
      applyStimulus(r, c, l, s, e, u, sa, int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_step_counter.md
# updown_step_counter

Parametrised up/down counter with programmable modulus, wrap or saturate mode, synchronous load/clear and a one-shot run sequencer (IDLE/RUN/DONE). It is the next-generation iteration counter for the sequential multiplication devices (Booth, shift-add). A datapath controller pulses `start`, steps the counter with `en`, and receives a single-cycle `done` when the programmed terminal value is reached. The counter can also be free-run as a general-purpose counter.

## Interface
- `WIDTH`, 4: counter width in bits, ≥ 2.
- `MAX_COUNT`, 2**WIDTH-1: highest legal count value (modulus − 1); 1 ≤ MAX_COUNT ≤ 2**WIDTH−1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `clr`  in  1  synchronous clear of count and sequencer.
- `load`  in  1  synchronous load of `load_value`; aborts any run.
- `start`  in  1  begin a run from `load_value`; honoured only in IDLE or DONE.
- `load_value`  in  WIDTH  load/start value; values > MAX_COUNT are clamped to MAX_COUNT.
- `en`  in  1  step enable (free-run in IDLE, iteration step in RUN).
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `sat`  in  1  boundary mode: 1 = saturate, 0 = wrap.
- `count`  out  WIDTH  registered count value.
- `tc`  out  1  combinational from `count`/`up`: 1 when `count` == terminal (MAX_COUNT if up, 0 if down).
- `wrap`  out  1  registered one-cycle pulse; high in the cycle `count` shows a wrapped value.
- `busy`  out  1  state == RUN.
- `done`  out  1  state == DONE, exactly one cycle per completed run.

## Operation
- Priority per edge: rst > clr > load > start > en step.
- rst or clr: count=0, state IDLE, wrap=0, done=0.
- load: count=clamp(load_value), state IDLE. This cancels a run without asserting done. wrap=0.
- start (state IDLE or DONE, no load/clr): count=clamp(load_value).
  - If that value already equals the terminal for the current `up`, go directly to DONE (zero-length run).
  - Otherwise go to RUN.
  - start in RUN is ignored.
- Step (en=1, no higher-priority event):
  - Up: count+1; from MAX_COUNT → 0 (wrap, pulse `wrap`) or hold (sat=1).
  - Down: count−1; from 0 → MAX_COUNT (wrap, pulse `wrap`) or hold (sat=1).
  - Count never exceeds MAX_COUNT.
- RUN: a step whose result equals the terminal moves to DONE. A run never wraps, and `wrap` stays 0 during a run. en=0 stalls: count holds and state holds.
- DONE: lasts exactly one cycle, then IDLE. Steps with en=1 in that cycle are applied as in IDLE. `up`/`sat` changes mid-run take effect on the next step, and terminal is re-evaluated each step.
- IDLE: free-running counter governed by en/up/sat.

## Timing
- Reset values: count=0, wrap=0, busy=0, done=0. tc=1 if up=0, else 0 (MAX_COUNT≠0).
- Load/start latency: 1 cycle, with `count` valid the cycle after the edge.
- Run of N steps from value v to terminal: busy high for N cycles of en=1 plus stall cycles. done is high in the cycle count first shows the terminal value.
- `wrap` coincides with the wrapped count, one cycle wide.
- rst asserted mid-run: the next cycle is IDLE/0 with no done pulse.

## Structure
- Package `counter_pkg`: `typedef enum logic [1:0] {CNT_IDLE, CNT_RUN, CNT_DONE} cnt_state_e`, plus a function `clamp_count` parametrised through module constants.
- One natural sub-module, `updown_step`: combinational next-value, wrap detect and saturate hold given count/up/sat/MAX_COUNT. The top module holds the count register, the FSM and output registers.

## Test plan
WIDTH=4, MAX_COUNT=9 unless noted.
- Reset: count at 5 in RUN, rst high 2 cycles → count=0, busy=0, done=0, wrap=0. No done pulse afterwards.
- Wrap up: load 7, up=1, sat=0, en=1 for 3 cycles → 8, 9 (tc=1), 0 with wrap=1 for one cycle only.
- Saturate down and clamp: load 12 → count=9. Then load 2, up=0, sat=1, en 4 cycles → 1, 0, 0, 0; tc=1 at 0; wrap never asserted.
- Run with stall: start with load_value=3, up=1. en=1 except 2 idle cycles → count steps 4..9. busy high throughout, count holds during stalls. done=1 only in the cycle count=9, then IDLE. Zero-length variant: start with load_value=9 → done next cycle, busy never high.
- Priority: load=1, start=1, en=1 same edge with load_value=4 → count=4, IDLE. clr with load → count=0. start during RUN → ignored, count unaffected.
- Edge parameters: WIDTH=2, MAX_COUNT=3 and MAX_COUNT=1 → down-wrap 0 → MAX_COUNT, with correct tc and wrap.
